// File: rtl/regfile_mp_if.sv
// Bus bundle for regfile_mp: byte-strobed write port, packed read ports and clear control.
// ParInj/RdErr exist only when REGFILE_PARITY_EN is defined.
interface regfile_mp_if #(
  parameter int WIDTH = 8,
  parameter int ADDR  = 6,
  parameter int NRD   = 2
);
  logic                 WrEn;
  logic [ADDR-1:0]      WrAddr;
  logic [WIDTH-1:0]     WrData;
  logic [WIDTH/8-1:0]   WrStrb;
  logic [NRD-1:0]       RdEn;
  logic [NRD*ADDR-1:0]  RdAddr;
  logic [NRD*WIDTH-1:0] RdData;
  logic [NRD-1:0]       RdData_VLD;
  logic                 ClrReq;
  logic                 Busy;
`ifdef REGFILE_PARITY_EN
  logic                 ParInj;
  logic [NRD-1:0]       RdErr;
`endif

  modport master (
    output WrEn, WrAddr, WrData, WrStrb, RdEn, RdAddr, ClrReq,
`ifdef REGFILE_PARITY_EN
    output ParInj,
    input  RdErr,
`endif
    input  RdData, RdData_VLD, Busy
  );

  modport slave (
    input  WrEn, WrAddr, WrData, WrStrb, RdEn, RdAddr, ClrReq,
`ifdef REGFILE_PARITY_EN
    input  ParInj,
    output RdErr,
`endif
    output RdData, RdData_VLD, Busy
  );
endinterface

// File: rtl/regfile_mp.sv
// Multi-read-port register file with byte-strobed write-first bypass and a sequential clear engine.
// Optional per-byte even parity storage and checking is enabled by defining REGFILE_PARITY_EN.
module regfile_mp #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 64,
  parameter int ADDR  = 6,
  parameter int NRD   = 2
) (
  input  logic        CLK,
  input  logic        RST,
  regfile_mp_if.slave bus
);
  localparam int NB = WIDTH / 8;

  typedef enum logic {IDLE, CLEAR} state_t;

  state_t               state_q, state_d;
  logic [ADDR-1:0]      cnt_q, cnt_d;
  logic                 busy;

  logic [WIDTH-1:0]     mem_q [DEPTH];
  logic [NRD*WIDTH-1:0] rdData_q, rdData_d;
  logic [NRD-1:0]       rdVld_q, rdVld_d;
  logic [ADDR-1:0]      rdAddr [NRD];

  logic                 wrInRange;
  logic                 wrActive;
  logic [WIDTH-1:0]     wrMerged;

`ifdef REGFILE_PARITY_EN
  logic [NB-1:0]        par_q [DEPTH];
  logic [NB-1:0]        wrPar;
  logic [NRD-1:0]       rdErr_q, rdErr_d;

  function automatic logic [NB-1:0] byteParity(input logic [WIDTH-1:0] d);
    logic [NB-1:0] p;
    p = '0;
    for (int k = 0; k < NB; k++) p[k] = ^d[8*k +: 8];
    return p;
  endfunction
`endif

  assign busy      = (state_q == CLEAR);
  assign wrInRange = int'(bus.WrAddr) < DEPTH;
  assign wrActive  = bus.WrEn && !busy && wrInRange;

  for (genvar p = 0; p < NRD; p++) begin : g_rdaddr
    assign rdAddr[p] = bus.RdAddr[p*ADDR +: ADDR];
  end

  // The merged word is both what gets stored and what a colliding read sees.
  always_comb begin
    wrMerged = mem_q[bus.WrAddr];
    for (int k = 0; k < NB; k++) begin
      if (bus.WrStrb[k]) wrMerged[8*k +: 8] = bus.WrData[8*k +: 8];
    end
  end

`ifdef REGFILE_PARITY_EN
  assign wrPar = byteParity(wrMerged) ^ {NB{bus.ParInj}};
`endif

  always_comb begin
    rdData_d = rdData_q;
    rdVld_d  = '0;
`ifdef REGFILE_PARITY_EN
    rdErr_d  = '0;
`endif
    for (int p = 0; p < NRD; p++) begin
      if (bus.RdEn[p] && !busy) begin
        rdVld_d[p] = 1'b1;
        if (int'(rdAddr[p]) >= DEPTH) begin
          rdData_d[p*WIDTH +: WIDTH] = '0;
        end else if (wrActive && rdAddr[p] == bus.WrAddr) begin
          rdData_d[p*WIDTH +: WIDTH] = wrMerged;
`ifdef REGFILE_PARITY_EN
          rdErr_d[p] = |(byteParity(wrMerged) ^ wrPar);
`endif
        end else begin
          rdData_d[p*WIDTH +: WIDTH] = mem_q[rdAddr[p]];
`ifdef REGFILE_PARITY_EN
          rdErr_d[p] = |(byteParity(mem_q[rdAddr[p]]) ^ par_q[rdAddr[p]]);
`endif
        end
      end
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (bus.ClrReq) begin
          state_d = CLEAR;
          cnt_d   = '0;
        end
      end
      CLEAR: begin
        if (int'(cnt_q) == DEPTH - 1) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + ADDR'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      rdData_q <= '0;
      rdVld_q  <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      rdData_q <= rdData_d;
      rdVld_q  <= rdVld_d;
    end
  end

  // The clear engine owns the array while busy, so writes never compete with it.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (busy) begin
      mem_q[cnt_q] <= '0;
    end else if (wrActive) begin
      mem_q[bus.WrAddr] <= wrMerged;
    end
  end

`ifdef REGFILE_PARITY_EN
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      for (int i = 0; i < DEPTH; i++) par_q[i] <= '0;
      rdErr_q <= '0;
    end else begin
      rdErr_q <= rdErr_d;
      if (busy) begin
        par_q[cnt_q] <= '0;
      end else if (wrActive) begin
        par_q[bus.WrAddr] <= wrPar;
      end
    end
  end

  assign bus.RdErr = rdErr_q;
`endif

  assign bus.RdData     = rdData_q;
  assign bus.RdData_VLD = rdVld_q;
  assign bus.Busy       = busy;

endmodule

// File: tb/tb_regfile_mp.sv
// Randomized bench for regfile_mp checked every cycle against an array-based reference model,
// plus directed literal checks; parity checks are included when REGFILE_PARITY_EN is defined.
module tb_regfile_mp;
  localparam int W  = 16;
  localparam int D  = 48;
  localparam int A  = 6;
  localparam int N  = 3;
  localparam int NB = W / 8;

  logic CLK = 1'b0;
  logic RST;
  int   total = 0;
  int   bad   = 0;

  always #5 CLK = ~CLK;

  regfile_mp_if #(.WIDTH(W), .ADDR(A), .NRD(N)) bus ();

  regfile_mp #(.WIDTH(W), .DEPTH(D), .ADDR(A), .NRD(N)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  logic [W-1:0] mdl [D];
  logic [W-1:0] expData [N];
  logic [N-1:0] expVld;
  logic         expBusy;
  int           clrLeft;
`ifdef REGFILE_PARITY_EN
  logic         mdlBad [D];
  logic [N-1:0] expErr;
`endif

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("[TB] FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic applyStimulus(input logic we, input int wa, input logic [W-1:0] wd,
                               input logic [NB-1:0] ws, input logic [N-1:0] re,
                               input logic [N*A-1:0] ra, input logic clr, input logic pinj);
    bus.WrEn   = we;
    bus.WrAddr = A'(wa);
    bus.WrData = wd;
    bus.WrStrb = ws;
    bus.RdEn   = re;
    bus.RdAddr = ra;
    bus.ClrReq = clr;
`ifdef REGFILE_PARITY_EN
    bus.ParInj = pinj;
`endif
    @(posedge CLK);
    #1;
  endtask

  function automatic logic [N*A-1:0] packAddr(input int a0, input int a1, input int a2);
    return {A'(a2), A'(a1), A'(a0)};
  endfunction

  // Reference model: a plain array, a remaining-clear-cycles count and the expected registered outputs.
  initial begin : model
    logic [W-1:0] mask;
    logic [W-1:0] merged;
    logic         wrOk;
    logic         pinj;
    int           wa;
    int           ra;
    forever begin
      @(posedge CLK or negedge RST);
      if (!RST) begin
        for (int i = 0; i < D; i++) mdl[i] = '0;
        for (int p = 0; p < N; p++) expData[p] = '0;
        expVld  = '0;
        expBusy = 1'b0;
        clrLeft = 0;
`ifdef REGFILE_PARITY_EN
        for (int i = 0; i < D; i++) mdlBad[i] = 1'b0;
        expErr = '0;
`endif
      end else if (clrLeft > 0) begin
        mdl[D - clrLeft] = '0;
`ifdef REGFILE_PARITY_EN
        mdlBad[D - clrLeft] = 1'b0;
        expErr = '0;
`endif
        clrLeft--;
        expVld  = '0;
        expBusy = (clrLeft > 0);
      end else begin
        pinj = 1'b0;
`ifdef REGFILE_PARITY_EN
        pinj = bus.ParInj;
        expErr = '0;
`endif
        wa   = int'(bus.WrAddr);
        wrOk = bus.WrEn && (wa < D);
        mask = '0;
        for (int k = 0; k < NB; k++) if (bus.WrStrb[k]) mask[8*k +: 8] = 8'hFF;
        merged = wrOk ? ((mdl[wa] & ~mask) | (bus.WrData & mask)) : '0;
        for (int p = 0; p < N; p++) begin
          expVld[p] = bus.RdEn[p];
          if (bus.RdEn[p]) begin
            ra = int'(bus.RdAddr[p*A +: A]);
            if (ra >= D) begin
              expData[p] = '0;
            end else if (wrOk && ra == wa) begin
              expData[p] = merged;
`ifdef REGFILE_PARITY_EN
              expErr[p] = pinj;
`endif
            end else begin
              expData[p] = mdl[ra];
`ifdef REGFILE_PARITY_EN
              expErr[p] = mdlBad[ra];
`endif
            end
          end
        end
        if (wrOk) begin
          mdl[wa] = merged;
`ifdef REGFILE_PARITY_EN
          mdlBad[wa] = pinj;
`endif
        end
        if (bus.ClrReq) clrLeft = D;
        expBusy = (clrLeft > 0);
        if (pinj && !wrOk) pinj = 1'b0;
      end
    end
  end

  initial begin : compare
    forever begin
      @(negedge CLK);
      checkOutput("Busy", 64'(bus.Busy), 64'(expBusy));
      for (int p = 0; p < N; p++) begin
        checkOutput($sformatf("VLD%0d", p), 64'(bus.RdData_VLD[p]), 64'(expVld[p]));
        checkOutput($sformatf("RdData%0d", p), 64'(bus.RdData[p*W +: W]), 64'(expData[p]));
`ifdef REGFILE_PARITY_EN
        checkOutput($sformatf("RdErr%0d", p), 64'(bus.RdErr[p]), 64'(expErr[p]));
`endif
      end
    end
  end

  initial begin : watchdog
    #2000000;
    $display("[TB] FAIL watchdog actual=timeout required=finish");
    $fatal(1, "[TB] simulation did not finish");
  end

  initial begin : stimulus
    int n;
    int wa;
    RST        = 1'b0;
    bus.WrEn   = 1'b0;
    bus.WrAddr = '0;
    bus.WrData = '0;
    bus.WrStrb = '0;
    bus.RdEn   = '0;
    bus.RdAddr = '0;
    bus.ClrReq = 1'b0;
`ifdef REGFILE_PARITY_EN
    bus.ParInj = 1'b0;
`endif
    repeat (3) @(posedge CLK);
    #3 RST = 1'b1;
    @(posedge CLK);
    #1;

    checkOutput("reset Busy", 64'(bus.Busy), 64'h0);
    checkOutput("reset RdData", 64'(bus.RdData), 64'h0);
    checkOutput("reset VLD", 64'(bus.RdData_VLD), 64'h0);

    applyStimulus(0, 0, '0, '0, 3'b111, packAddr(0, D-1, 0), 0, 0);
    checkOutput("first read VLD", 64'(bus.RdData_VLD), 64'h7);
    checkOutput("first read data", 64'(bus.RdData), 64'h0);
    applyStimulus(0, 0, '0, '0, 3'b000, '0, 0, 0);
    checkOutput("VLD pulse ends", 64'(bus.RdData_VLD), 64'h0);

    applyStimulus(1, 5, 16'h00A5, 2'b11, 3'b000, '0, 0, 0);
    applyStimulus(0, 0, '0, '0, 3'b111, packAddr(5, 5, 5), 0, 0);
    checkOutput("multi read VLD", 64'(bus.RdData_VLD), 64'h7);
    checkOutput("multi read data", 64'(bus.RdData), {16'h0, 48'h00A5_00A5_00A5});

    applyStimulus(1, 3, 16'h1234, 2'b11, 3'b000, '0, 0, 0);
    applyStimulus(1, 3, 16'hABCD, 2'b10, 3'b000, '0, 0, 0);
    applyStimulus(0, 0, '0, '0, 3'b001, packAddr(3, 0, 0), 0, 0);
    checkOutput("strobe merge", 64'(bus.RdData[15:0]), 64'hAB34);
    applyStimulus(1, 3, 16'hFFFF, 2'b00, 3'b000, '0, 0, 0);
    applyStimulus(0, 0, '0, '0, 3'b010, packAddr(0, 3, 0), 0, 0);
    checkOutput("zero strobe no-op", 64'(bus.RdData[31:16]), 64'hAB34);

    applyStimulus(1, 7, 16'h1111, 2'b11, 3'b000, '0, 0, 0);
    applyStimulus(1, 7, 16'h2222, 2'b11, 3'b001, packAddr(7, 0, 0), 0, 0);
    checkOutput("bypass full", 64'(bus.RdData[15:0]), 64'h2222);
    applyStimulus(1, 7, 16'h0033, 2'b01, 3'b110, packAddr(0, 7, 7), 0, 0);
    checkOutput("bypass merged", 64'(bus.RdData[47:16]), 64'h2233_2233);
    applyStimulus(0, 0, '0, '0, 3'b001, packAddr(7, 0, 0), 0, 0);
    checkOutput("after bypass", 64'(bus.RdData[15:0]), 64'h2233);

    applyStimulus(1, 60, 16'hFFFF, 2'b11, 3'b110, packAddr(0, 60, 50), 0, 0);
    checkOutput("out of range VLD", 64'(bus.RdData_VLD), 64'h6);
    checkOutput("out of range data", 64'(bus.RdData[47:16]), 64'h0);

`ifdef REGFILE_PARITY_EN
    applyStimulus(1, 2, 16'h000F, 2'b11, 3'b000, '0, 0, 1);
    applyStimulus(0, 0, '0, '0, 3'b001, packAddr(2, 0, 0), 0, 0);
    checkOutput("parity inject err", 64'(bus.RdErr[0]), 64'h1);
    applyStimulus(1, 2, 16'h000F, 2'b11, 3'b000, '0, 0, 0);
    applyStimulus(0, 0, '0, '0, 3'b001, packAddr(2, 0, 0), 0, 0);
    checkOutput("parity clean err", 64'(bus.RdErr[0]), 64'h0);
    applyStimulus(1, 2, 16'h0001, 2'b01, 3'b001, packAddr(2, 0, 0), 0, 1);
    checkOutput("parity bypass err", 64'(bus.RdErr[0]), 64'h1);
`endif

    for (int i = 0; i < D; i++) applyStimulus(1, i, W'($urandom) | 16'h0101, 2'b11, 3'b000, '0, 0, 0);
    applyStimulus(1, 9, 16'hBEEF, 2'b11, 3'b001, packAddr(9, 0, 0), 1, 0);
    checkOutput("clear start Busy", 64'(bus.Busy), 64'h1);
    checkOutput("clear start read", 64'(bus.RdData[15:0]), 64'hBEEF);
    n = 0;
    while (bus.Busy === 1'b1 && n < 200) begin
      applyStimulus(1, 9, 16'h5555, 2'b11, 3'b111, packAddr(9, 9, 1), (n == 10), 0);
      n++;
      if (n == 3) checkOutput("busy VLD", 64'(bus.RdData_VLD), 64'h0);
    end
    checkOutput("clear length", 64'(n), 64'(D));
    for (int i = 0; i < D; i += N) begin
      applyStimulus(0, 0, '0, '0, 3'b111, packAddr(i, (i + 1) % D, (i + 2) % D), 0, 0);
      checkOutput($sformatf("cleared @%0d", i), 64'(bus.RdData), 64'h0);
    end

    applyStimulus(1, 20, 16'h7777, 2'b11, 3'b000, '0, 0, 0);
    applyStimulus(0, 0, '0, '0, 3'b000, '0, 1, 0);
    repeat (5) applyStimulus(0, 0, '0, '0, 3'b000, '0, 0, 0);
    #2 RST = 1'b0;
    #1;
    checkOutput("abort Busy", 64'(bus.Busy), 64'h0);
    @(posedge CLK);
    #3 RST = 1'b1;
    @(posedge CLK);
    #1;
    applyStimulus(0, 0, '0, '0, 3'b001, packAddr(20, 0, 0), 0, 0);
    checkOutput("reset zeroes array", 64'(bus.RdData[15:0]), 64'h0);

    for (int c = 0; c < 2500; c++) begin
      logic [N*A-1:0] ra;
      wa = int'($urandom_range(0, 63));
      for (int p = 0; p < N; p++) begin
        ra[p*A +: A] = ($urandom_range(0, 2) == 0) ? A'(wa) : A'($urandom_range(0, 63));
      end
      applyStimulus(1'($urandom_range(0, 1)), wa, W'($urandom), NB'($urandom), N'($urandom),
                    ra, ($urandom_range(0, 299) == 0), ($urandom_range(0, 7) == 0));
    end
    repeat (2) applyStimulus(0, 0, '0, '0, 3'b000, '0, 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
